// File: rtl/rx_lane_arb.sv
// rx_lane_arb -- four-lane round-robin write arbiter into a double-buffered
// frame memory.
//
// Each lane holds req/last/wdata until granted. The winning lane gets a burst
// of up to BURST beats. The burst ends early on a beat with last set, or in
// the first cycle the owner drops req. Every burst is followed by one IDLE
// bubble. A frame_sync pulse is remembered until the arbiter is next in IDLE.
// Then a one-cycle SWAP flips the write bank, hands the finished bank to the
// reader, and clears all lane pointers.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req[3:0]           per-lane write request
//   last[3:0]          per-lane end-of-line marker (qualified by req)
//   wdata[4*DW-1:0]    per-lane pixel data, lane i at [i*DW +: DW]
//   frame_sync         single-cycle frame boundary pulse
//   gnt[3:0]           one-hot grant, only while bursting
//   mem_we/addr/wdata  registered write port, addr = {wr_bank, lane, ptr}
//   wr_bank, rd_bank   bank being written / last completed bank
//   frame_done         one-cycle pulse coinciding with the bank flip
//   stat_beats         (RX_ARB_STATS_EN only) previous-frame beat count per lane
//
// Optional feature macro: RX_ARB_STATS_EN

// Per-lane write pointer, plus the optional beat counter.
module rx_lane_arb_lane #(
  parameter int PW = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
`ifdef RX_ARB_STATS_EN
  ,
  output logic [15:0]   stat
`endif
);
  // The pointer wraps naturally at 2^PW.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)    ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;

`ifdef RX_ARB_STATS_EN
  logic [15:0] live;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      live <= '0;
      stat <= '0;
    end else if (clr) begin
      stat <= live;
      live <= '0;
    end else if (inc && live != 16'hFFFF) begin
      live <= live + 16'd1;
    end
`endif
endmodule

module rx_lane_arb #(
  parameter int DW    = 24,
  parameter int AW    = 17,
  parameter int BURST = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           req,
  input  logic [3:0]           last,
  input  logic [4*DW-1:0]      wdata,
  input  logic                 frame_sync,
  output logic [3:0]           gnt,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 wr_bank,
  output logic                 rd_bank,
  output logic                 frame_done
`ifdef RX_ARB_STATS_EN
  ,
  output logic [3:0][15:0]     stat_beats
`endif
);
  localparam int PW = AW - 3;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_SWAP} state_t;

  state_t               state, state_nx;
  logic [1:0]           owner, last_owner, pick;
  logic [7:0]           beats;
  logic                 sync_pend, any_sync, xfer, burst_end;
  logic [3:0][DW-1:0]   wd;
  logic [3:0][PW-1:0]   ptr;
  logic [3:0]           inc;

  assign wd        = wdata;
  assign any_sync  = sync_pend | frame_sync;
  assign xfer      = (state == S_BURST) && req[owner];
  assign burst_end = xfer && ((beats == 8'(BURST - 1)) || last[owner]);

  // Round-robin search from last_owner+1 upward. The loop runs downward so
  // that the nearest requesting lane is the one left in pick.
  always_comb begin
    pick = last_owner;
    for (int k = 4; k >= 1; k--)
      if (req[last_owner + 2'(k)]) pick = last_owner + 2'(k);
  end

  always_comb begin
    state_nx = state;
    gnt      = '0;
    case (state)
      S_IDLE:  if (any_sync) state_nx = S_SWAP;
               else if (|req) state_nx = S_BURST;
      S_BURST: begin
        gnt[owner] = 1'b1;
        if (!req[owner] || burst_end) state_nx = S_IDLE;
      end
      S_SWAP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= S_IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      beats      <= '0;
      sync_pend  <= 1'b0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      frame_done <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      mem_we     <= xfer;
      frame_done <= (state == S_SWAP);
      if (xfer) begin
        mem_addr  <= {wr_bank, owner, ptr[owner]};
        mem_wdata <= wd[owner];
        beats     <= beats + 8'd1;
      end
      if (state == S_IDLE && !any_sync && |req) begin
        owner      <= pick;
        last_owner <= pick;
        beats      <= '0;
      end
      // A sync landing in the SWAP cycle itself is kept for the next frame.
      if (state == S_SWAP) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        sync_pend <= frame_sync;
      end else if (frame_sync) begin
        sync_pend <= 1'b1;
      end
    end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign inc[i] = xfer && (owner == 2'(i));
    rx_lane_arb_lane #(.PW(PW)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .inc  (inc[i]),
      .clr  (state == S_SWAP),
      .ptr  (ptr[i])
`ifdef RX_ARB_STATS_EN
      ,
      .stat (stat_beats[i])
`endif
    );
  end
endmodule

// File: tb/tb_rx_lane_arb.sv
// Bench for rx_lane_arb. A behavioural model predicts grants, writes, bank
// state and frame_done every cycle. The write log is pinned by hand-computed
// addresses for each directed scenario.
module tb_rx_lane_arb;
  localparam int DW = 24, AW = 17, PW = 14;
  localparam int LANE = 1 << PW, BANK = 1 << (PW + 2);

  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] req = '0, last = '0;
  logic [4*DW-1:0] wdata = '0;
  logic frame_sync = 1'b0;
  logic [3:0] gnt;
  logic mem_we, wr_bank, rd_bank, frame_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
`ifdef RX_ARB_STATS_EN
  logic [3:0][15:0] stat_beats;
`endif

  always #5 clk = ~clk;

  rx_lane_arb dut (
    .clk(clk), .rstn(rstn), .req(req), .last(last), .wdata(wdata),
    .frame_sync(frame_sync), .gnt(gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_done(frame_done)
`ifdef RX_ARB_STATS_EN
    , .stat_beats(stat_beats)
`endif
  );

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy: a lane owns the bus; swap_now: this cycle is the bank swap.
  bit m_busy, m_swap, m_pend;
  int m_own, m_prev, m_beats, m_wb, m_rb;
  int m_ptr[4];
  logic e_we, e_fd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  task automatic model_tick();
    bit found;
    if (!rstn) begin
      m_busy = 0; m_swap = 0; m_pend = 0; m_own = 0; m_prev = 3; m_beats = 0;
      m_wb = 0; m_rb = 1; foreach (m_ptr[i]) m_ptr[i] = 0;
      e_we = 0; e_fd = 0; e_addr = '0; e_wd = '0;
    end else begin
      e_we = 0; e_fd = 0;
      if (m_busy) begin
        if (req[m_own]) begin
          e_we   = 1;
          e_addr = AW'(m_wb * BANK + m_own * LANE + m_ptr[m_own]);
          e_wd   = wdata[m_own*DW +: DW];
          m_ptr[m_own] = (m_ptr[m_own] + 1) % LANE;
          m_beats++;
          if (m_beats == 8 || last[m_own]) m_busy = 0;
        end else m_busy = 0;
        if (frame_sync) m_pend = 1;
      end else if (m_swap) begin
        m_rb = m_wb; m_wb = 1 - m_wb;
        foreach (m_ptr[i]) m_ptr[i] = 0;
        m_pend = frame_sync; e_fd = 1; m_swap = 0;
      end else if (m_pend || frame_sync) begin
        m_swap = 1; m_pend = 1;
      end else if (req != 0) begin
        found = 0;
        for (int k = 1; k <= 4; k++)
          if (!found && req[(m_prev + k) % 4]) begin
            m_own = (m_prev + k) % 4; found = 1;
          end
        m_prev = m_own; m_beats = 0; m_busy = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rstn) model_tick();

  // ---------------- compare process ----------------
  logic [31:0] wlog[$];
  int fd_cnt = 0;

  task automatic check_tick();
    chk("gnt", gnt, m_busy ? (32'd1 << m_own) : 32'd0);
    chk("mem_we", mem_we, e_we);
    if (e_we) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
    end
    chk("frame_done", frame_done, e_fd);
    chk("wr_bank", wr_bank, 32'(m_wb));
    chk("rd_bank", rd_bank, 32'(m_rb));
    if (mem_we) wlog.push_back(32'(mem_addr));
    if (frame_done) fd_cnt++;
  endtask

  always @(negedge clk) check_tick();

  function automatic logic [31:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 32'hxxxx_xxxx;
  endfunction

  // ---------------- lane sources ----------------
  int src_cnt[4], src_last_at[4], src_done[4], src_seq[4];
  logic [3:0] xnext = '0;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]  = src_cnt[i] > 0;
      last[i] = req[i] && src_last_at[i] != 0 && src_done[i] + 1 == src_last_at[i];
      wdata[i*DW +: DW] = 24'((i << 20) | (src_seq[i] & 'hFFFFF));
    end
  endtask

  // Apply the beat (if any) taken at the previous edge, then present new inputs.
  task automatic step(input logic fs);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (xnext[i]) begin src_cnt[i]--; src_done[i]++; src_seq[i]++; end
    drive();
    frame_sync = fs;
    xnext = req & gnt;
  endtask

  task automatic load(input int lane, input int cnt, input int last_at);
    src_cnt[lane] = cnt; src_last_at[lane] = last_at; src_done[lane] = 0;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((src_cnt[0] + src_cnt[1] + src_cnt[2] + src_cnt[3]) != 0 && n < budget) begin
      step(1'b0); n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'd0);
    repeat (6) step(1'b0);
  endtask

  int wb, fd0, n;

  initial begin
    foreach (src_cnt[i]) begin
      src_cnt[i] = 0; src_last_at[i] = 0; src_done[i] = 0; src_seq[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);          chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fd", frame_done, 0);    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    @(negedge clk) rstn = 1'b1;

    // All four lanes requesting continuously.
    wb = wlog.size();
    for (int i = 0; i < 4; i++) load(i, 16, 0);
    run_idle(500);
    chk("s1_count", wlog.size() - wb, 64);
    chk("s1_w0", wl(wb + 0), 0);           chk("s1_w7", wl(wb + 7), 7);
    chk("s1_w8", wl(wb + 8), LANE);        chk("s1_w16", wl(wb + 16), 2 * LANE);
    chk("s1_w31", wl(wb + 31), 3 * LANE + 7);
    chk("s1_w32", wl(wb + 32), 8);         chk("s1_w63", wl(wb + 63), 3 * LANE + 15);

    // Lane2 alone, last on beat 3, then the rest of its queue.
    wb = wlog.size();
    load(2, 5, 3);
    run_idle(200);
    chk("s2_count", wlog.size() - wb, 5);
    chk("s2_w0", wl(wb + 0), 2 * LANE + 16);
    chk("s2_w2", wl(wb + 2), 2 * LANE + 18);
    chk("s2_w3", wl(wb + 3), 2 * LANE + 19);

    // frame_sync during beat 4 of an 8-beat burst.
    wb = wlog.size(); fd0 = fd_cnt;
    load(1, 8, 0);
    n = 0;
    while (src_cnt[1] > 5 && n < 100) begin step(1'b0); n++; end
    chk("s3_timeout", 32'(n >= 100), 0);
    frame_sync = 1'b1;
    run_idle(200);
    chk("s3_count", wlog.size() - wb, 8);
    chk("s3_w7", wl(wb + 7), LANE + 23);
    chk("s3_fd", fd_cnt - fd0, 1);
    chk("s3_wr_bank", wr_bank, 1);         chk("s3_rd_bank", rd_bank, 0);
    wb = wlog.size();
    load(1, 1, 0);
    run_idle(100);
    chk("s3_new_bank", wl(wb), BANK + LANE);

    // frame_sync and req[1] in the same IDLE cycle.
    wb = wlog.size(); fd0 = fd_cnt;
    load(1, 1, 0);
    step(1'b1);
    run_idle(100);
    chk("s4_w0", wl(wb), LANE);
    chk("s4_fd", fd_cnt - fd0, 1);
    chk("s4_wr_bank", wr_bank, 0);         chk("s4_rd_bank", rd_bank, 1);

    // Reset in the middle of a burst.
    load(0, 8, 0);
    n = 0;
    while (src_cnt[0] > 5 && n < 100) begin step(1'b0); n++; end
    chk("s6_timeout", 32'(n >= 100), 0);
    #2 rstn = 1'b0;
    #1;
    chk("s6_gnt", gnt, 0);                 chk("s6_we", mem_we, 0);
    foreach (src_cnt[i]) src_cnt[i] = 0;
    xnext = '0;
    drive();
    @(negedge clk);
    @(negedge clk) rstn = 1'b1;
    wb = wlog.size();
    for (int i = 0; i < 4; i++) load(i, 1, 0);
    run_idle(100);
    chk("s6_first", wl(wb), 0);            chk("s6_second", wl(wb + 1), LANE);
    chk("s6_wr_bank", wr_bank, 0);         chk("s6_rd_bank", rd_bank, 1);

    // Pointer wrap: bring lane3's pointer to 2^PW-2, then 4 more beats.
    load(3, LANE - 3, 0);
    run_idle(25000);
    wb = wlog.size();
    load(3, 4, 0);
    run_idle(100);
    chk("s5_w0", wl(wb + 0), 3 * LANE + LANE - 2);
    chk("s5_w1", wl(wb + 1), 3 * LANE + LANE - 1);
    chk("s5_w2", wl(wb + 2), 3 * LANE);
    chk("s5_w3", wl(wb + 3), 3 * LANE + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end
endmodule

// File: doc/rx_lane_arb.md
RX_LANE_ARB -- requirements
Module: rx_lane_arb

Interface
REQ-001 SHALL have parameter DW, 24, pixel word width.
REQ-002 SHALL have parameter AW, 17, memory address width; lane pointer width PW = AW-3.
REQ-003 SHALL have parameter BURST, 8, maximum beats per grant (1..255).
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req  in  4  per-lane write request, held with data until granted.
REQ-007 SHALL have port last  in  4  per-lane end-of-line marker, qualified by req.
REQ-008 SHALL have port wdata  in  4*DW  per-lane pixel data, lane i at [i*DW +: DW].
REQ-009 SHALL have port frame_sync  in  1  single-cycle frame boundary pulse from the receiver.
REQ-010 SHALL have port gnt  out  4  per-lane grant; beat transfers when req[i] and gnt[i] are both high.
REQ-011 SHALL have port mem_we  out  1  shared frame-memory write enable.
REQ-012 SHALL have port mem_addr  out  AW  write address {wr_bank, lane[1:0], ptr[PW-1:0]}.
REQ-013 SHALL have port mem_wdata  out  DW  write data.
REQ-014 SHALL have port wr_bank  out  1  bank currently being written.
REQ-015 SHALL have port rd_bank  out  1  last completed bank, for the display reader.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse on bank swap.

Function
REQ-017 SHALL implement FSM states IDLE, BURST, SWAP.
REQ-018 SHALL, in IDLE with pending frame sync, enter SWAP; swap takes priority over any req in the same cycle.
REQ-019 SHALL, in IDLE with no pending sync and any req high, select owner round-robin from (last_owner+1) mod 4 upward, then enter BURST.
REQ-020 SHALL drive gnt as one-hot gnt[owner] only in BURST, zero in IDLE and SWAP.
REQ-021 SHALL register each transfer: mem_we, mem_addr, mem_wdata valid exactly 1 cycle after the transfer cycle; mem_we low otherwise.
REQ-022 SHALL increment ptr[owner] by 1 per transfer, wrapping from 2^PW-1 to 0 without error.
REQ-023 SHALL leave BURST for IDLE after the transfer completing BURST beats, after a transfer with last high, or in any cycle where req[owner] is low (no beat consumed).
REQ-024 SHALL impose one IDLE bubble cycle between consecutive bursts.
REQ-025 SHALL set a sticky sync_pend flag on frame_sync in any state; further pulses while pending merge into one.
REQ-026 SHALL defer a frame_sync arriving in BURST until the burst ends; no beat is lost or redirected.
REQ-027 SHALL, in SWAP (one cycle): rd_bank <= wr_bank, wr_bank <= ~wr_bank, clear all four ptrs, clear sync_pend, pulse frame_done, return to IDLE.
REQ-028 SHALL not alter last_owner in SWAP; fairness carries across frames.

Reset
REQ-029 SHALL, on rstn low, immediately force state IDLE, gnt 0, mem_we 0, mem_addr 0, mem_wdata 0, frame_done 0, sync_pend 0, ptrs 0, last_owner 3, wr_bank 0, rd_bank 1.
REQ-030 SHALL abandon a burst in progress on reset; no mem_we is issued from the aborted beat.
REQ-031 SHALL release reset synchronously; the first arbitration occurs in the first cycle after rstn rises.

Configuration
REQ-032 SHALL, with RX_ARB_STATS_EN defined, add output stat_beats (4x16 bits) holding the per-lane transfer counts of the previous frame, latched in SWAP; live counters saturate at 16'hFFFF and clear in SWAP; all bits reset to 0.
REQ-033 SHALL, without RX_ARB_STATS_EN, omit stat_beats and all counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: all four req high continuously, last=0 -> grants lane0,1,2,3,0 in order, 8 beats each, 1 bubble between bursts, addresses lane*2^PW+0..7.
REQ-035 SHALL cover: lane2 only, last high on beat 3 -> 3 mem_we pulses, then IDLE; next grant restarts at ptr 3.
REQ-036 SHALL cover: frame_sync on beat 4 of an 8-beat burst -> all 8 beats written to bank 0, then SWAP: frame_done=1, wr_bank=1, rd_bank=0, next address lane*2^PW+0 in bank 1.
REQ-037 SHALL cover: frame_sync and req[1] in the same IDLE cycle -> SWAP first, lane1 granted the following cycle.
REQ-038 SHALL cover: ptr preloaded to 2^PW-2 with 4 beats -> address wraps to offset 0 within the same lane/bank.
REQ-039 SHALL cover: rstn low mid-burst -> gnt and mem_we 0 immediately; after release, lane0 granted first, wr_bank=0, rd_bank=1.
